oam_dma_arbiter: RTL

Owns the shared external/video memory bus between the SM83 core and the OAM DMA engine. On a CPU write to the DMA page register it sequences a 160-byte copy from `{page, 00..9F}` into OAM, one byte per M-cycle. While the copy runs, it asserts `BUS_DISABLE` toward the sequencer so that CPU accesses outside `FF00-FFFF` cannot reach the bus.

---
 rtl/oam_dma_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/oam_dma_arbiter.sv
// OAM DMA arbiter: sequences 160-byte page copies into OAM and gates the CPU bus.
// Define OAM_DMA_RESTART_EN to let a page write during a copy restart it.
module oam_dma_arbiter (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic        MCYC,
  input  logic        DMA_WR,
  input  logic [7:0]  DMA_PAGE,
  input  logic        CPU_MREQ,
  input  logic [15:0] CPU_ADDR,
  output logic        BUS_DISABLE,
  output logic        OAM_BLOCK,
  output logic        DMA_ACTIVE,
  output logic        DMA_RD,
  output logic        OAM_WR,
  output logic [15:0] DMA_ADDR,
  output logic [7:0]  OAM_ADDR
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    XFER    = 2'd2,
    RESTART = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        pending;
  logic        pending_nx;
  logic [7:0]  page;
  logic [7:0]  page_nx;
  logic [7:0]  idx;
  logic [7:0]  idx_nx;
  logic [15:0] addr;
  logic [15:0] addr_nx;
  logic        wr_ok;
  logic        req;
  logic        echo;
  logic        addr_lo_unused;

  assign addr_lo_unused = ^CPU_ADDR[7:0];

`ifdef OAM_DMA_RESTART_EN
  assign wr_ok = DMA_WR;
`else
  assign wr_ok = DMA_WR & (state == IDLE);
`endif

  // A write on the same edge counts as already pending.
  assign req  = pending | wr_ok;
  assign echo = &page_nx[7:5];

  // Next-state, counter and source-address computation.
  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    pending_nx = req;
    page_nx    = wr_ok ? DMA_PAGE : page;
    addr_nx    = addr;
    if (MCYC) begin
      unique case (state)
        IDLE: begin
          if (req) begin
            state_nx   = START;
            pending_nx = 1'b0;
          end
        end
        START: begin
          state_nx = XFER;
          idx_nx   = 8'd0;
        end
        XFER: begin
`ifdef OAM_DMA_RESTART_EN
          if (req) begin
            state_nx   = RESTART;
            pending_nx = 1'b0;
            idx_nx     = 8'd0;
          end else if (idx == 8'd159) begin
            state_nx = IDLE;
            idx_nx   = 8'd0;
          end else begin
            idx_nx = idx + 8'd1;
          end
`else
          if (idx == 8'd159) begin
            state_nx = IDLE;
            idx_nx   = 8'd0;
          end else begin
            idx_nx = idx + 8'd1;
          end
`endif
        end
        RESTART: begin
          state_nx = XFER;
          idx_nx   = 8'd0;
        end
      endcase
      // Echo-RAM pages E0-FF fold down onto C000-DFFF.
      if (state_nx == XFER) begin
        addr_nx = {page_nx[7:6], page_nx[5] & ~echo,
                   page_nx[4:0], idx_nx};
      end else begin
        addr_nx = 16'h0000;
      end
    end
  end

  // State, counter, page and address registers; reset wins over writes.
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      state   <= IDLE;
      pending <= 1'b0;
      page    <= 8'h00;
      idx     <= 8'h00;
      addr    <= 16'h0000;
    end else begin
      state   <= state_nx;
      pending <= pending_nx;
      page    <= page_nx;
      idx     <= idx_nx;
      addr    <= addr_nx;
    end
  end

  assign DMA_ACTIVE  = (state != IDLE);
  assign DMA_RD      = (state == XFER);
  assign OAM_WR      = (state == XFER);
  assign OAM_BLOCK   = (state == XFER) | (state == RESTART);
  assign BUS_DISABLE = OAM_BLOCK & CPU_MREQ
                     & (CPU_ADDR[15:8] != 8'hFF);
  assign DMA_ADDR    = addr;
  assign OAM_ADDR    = idx;

endmodule
